// File: rtl/l2c_cbus_arb.sv
// l2c_cbus_arb: round-robin arbiter from PORT_NUM L1-side masters into a
// single registered request slot feeding the L2C cache-bus port.
//
// Handshake semantics (both sides):
//   L1 side : l1_req[i] is a valid that the master holds, with stable fields,
//             until l1_ack[i] pulses. l1_ack[i] is the ready and is asserted
//             combinationally in the cycle the request is copied into the slot.
//   L2C side: req is the valid. cmd/addr/uid/data_be/data stay bit-stable
//             while req=1 and ack=0. ack is the ready, combinational from L2C.
//             A transfer happens in any cycle with req=1 and ack=1.
module l2c_cbus_arb #(
  parameter int PORT_NUM = 4,
  parameter int CMD_W    = 2,
  parameter int ADDR_W   = 32,
  parameter int UID_W    = 8,
  parameter int DATA_W   = 32,
  parameter int BE_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORT_NUM-1:0]        l1_req,
  input  logic [PORT_NUM*CMD_W-1:0]  l1_cmd,
  input  logic [PORT_NUM*ADDR_W-1:0] l1_addr,
  input  logic [PORT_NUM*UID_W-1:0]  l1_uid,
  input  logic [PORT_NUM*BE_W-1:0]   l1_data_be,
  input  logic [PORT_NUM*DATA_W-1:0] l1_data,
  output logic [PORT_NUM-1:0]        l1_ack,
  output logic                       req,
  output logic [CMD_W-1:0]           cmd,
  output logic [ADDR_W-1:0]          addr,
  output logic [UID_W-1:0]           uid,
  output logic [BE_W-1:0]            data_be,
  output logic [DATA_W-1:0]          data,
  input  logic                       ack
);

  localparam int PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [UID_W-1:0]  uid;
    logic [BE_W-1:0]   data_be;
    logic [DATA_W-1:0] data;
  } slot_t;

  state_e            state_q, state_d;
  slot_t             slot_q, slot_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              any_req;
  logic              cap;
  logic              win_found;
  logic [PTR_W-1:0]  win;
  logic [PORT_NUM-1:0] win_onehot;
  slot_t             win_slot;
  int                idx;

  assign any_req = |l1_req;

  // Winner search: first asserted port after rr_ptr, wrapping at PORT_NUM.
  always_comb begin
    win        = '0;
    win_found  = 1'b0;
    win_onehot = '0;
    win_slot   = '0;
    idx        = 0;
    for (int k = 1; k <= PORT_NUM; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= PORT_NUM) idx = idx - PORT_NUM;
      if (!win_found && l1_req[idx]) begin
        win_found        = 1'b1;
        win              = PTR_W'(idx);
        win_onehot[idx]  = 1'b1;
        win_slot.cmd     = l1_cmd[CMD_W*idx +: CMD_W];
        win_slot.addr    = l1_addr[ADDR_W*idx +: ADDR_W];
        win_slot.uid     = l1_uid[UID_W*idx +: UID_W];
        win_slot.data_be = l1_data_be[BE_W*idx +: BE_W];
        win_slot.data    = l1_data[DATA_W*idx +: DATA_W];
      end
    end
  end

  // Slot FSM: capture when empty or when the current request is being accepted.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    rr_ptr_d = rr_ptr_q;
    cap      = 1'b0;
    case (state_q)
      ST_EMPTY: cap = any_req;
      ST_FULL: begin
        if (ack) begin
          cap = any_req;
          if (!any_req) begin
            state_d = ST_EMPTY;
            slot_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        slot_d  = '0;
      end
    endcase
    // No master may be acked while reset is held: its request would be lost.
    if (rst) cap = 1'b0;
    if (cap && win_found) begin
      state_d  = ST_FULL;
      slot_d   = win_slot;
      rr_ptr_d = win;
    end
    l1_ack = (cap && win_found) ? win_onehot : '0;
  end

  // State, slot and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      slot_q   <= '0;
      rr_ptr_q <= PTR_W'(PORT_NUM - 1);
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // L2C-side outputs; fields are forced to zero whenever the slot is empty.
  always_comb begin
    req     = (state_q == ST_FULL);
    cmd     = req ? slot_q.cmd     : '0;
    addr    = req ? slot_q.addr    : '0;
    uid     = req ? slot_q.uid     : '0;
    data_be = req ? slot_q.data_be : '0;
    data    = req ? slot_q.data    : '0;
  end

endmodule
